fft_frame_sequencer: RTL and testbench

Sequences one FFT frame through the audio spectrum path: on `start` it reads N real samples from the sample buffer BRAM and streams them into the xfft core over AXI-stream. It sends the core's config word on the first frame after reset, then collects the N output bins. It writes a 16-bit magnitude estimate for bins 0..N/2-1 into port A of the FFT output buffer BRAM. It sits between the filter/sample buffer and the display/readout logic, and it is the only master of the xfft slave ports and of the output buffer write port.

---
 rtl/fft_frame_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Moves one FFT frame through the xfft core. On an accepted start it sends the
//   core's config word (first frame after reset only). It then streams N real
//   samples from the sample buffer BRAM into the core. It collects the N output
//   bins and writes a 16-bit magnitude estimate for bins 0..N/2-1 into the
//   output buffer BRAM.
//
// Ports
//   clock, reset_n            : single clock, asynchronous active-low reset
//   start / busy / done / err : frame control, status and sticky tlast-mismatch flag
//   sbuf_en/addr/dout         : sample buffer read port (1-cycle read latency)
//   cfg_tdata/tvalid/tready   : xfft config channel
//   s_tdata/tvalid/tready/tlast : xfft input stream {16'h0000 imag, real sample}
//   m_tdata/tvalid/tready/tlast : xfft output stream {imag, real}, both signed
//   obuf_en/we/addr/din       : output buffer write port (unsigned magnitudes)
module fft_frame_sequencer #(
   parameter int          LOG2N    = 10,
   parameter logic [15:0] CFG_WORD = 16'h0001
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             sbuf_en,
   output logic [LOG2N-1:0] sbuf_addr,
   input  logic [15:0]      sbuf_dout,
   output logic [15:0]      cfg_tdata,
   output logic             cfg_tvalid,
   input  logic             cfg_tready,
   output logic [31:0]      s_tdata,
   output logic             s_tvalid,
   input  logic             s_tready,
   output logic             s_tlast,
   input  logic [31:0]      m_tdata,
   input  logic             m_tvalid,
   output logic             m_tready,
   input  logic             m_tlast,
   output logic             obuf_en,
   output logic             obuf_we,
   output logic [LOG2N-1:0] obuf_addr,
   output logic [15:0]      obuf_din
);

   typedef enum logic [2:0] {IDLE, CONFIG, LOAD, UNLOAD, FLUSH} state_t;

   state_t state, state_next;

   logic             cfg_sent;
   logic             accept;
   logic             cfg_hs;

   // Load path: read counter (one extra bit marks "all N reads issued"),
   // beat counter, BRAM read-in-flight flag, output register and skid register.
   logic [LOG2N:0]   rd_cnt;
   logic [LOG2N-1:0] snd_cnt;
   logic             rd_vld;
   logic             out_v, skid_v;
   logic [15:0]      out_data, skid_data;
   logic             s_pop;
   logic [1:0]       occ_now, occ_next;
   logic             rd_issue;

   // Unload path
   logic [LOG2N-1:0] j_cnt;
   logic             m_hs;
   logic             j_last;
   logic [15:0]      abs_re, abs_im, mag_hi, mag_lo, mag;

   // A start that lands on the done cycle is ignored.
   assign accept = start && (state == IDLE) && !done;
   assign cfg_hs = (state == CONFIG) && cfg_tready;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      cfg_tvalid = 1'b0;
      cfg_tdata  = '0;
      m_tready   = 1'b0;
      unique case (state)
         IDLE:   if (accept) state_next = cfg_sent ? LOAD : CONFIG;
         CONFIG: begin
            cfg_tvalid = 1'b1;
            cfg_tdata  = CFG_WORD;
            if (cfg_tready) state_next = LOAD;
         end
         LOAD:   if (s_pop && (&snd_cnt)) state_next = UNLOAD;
         UNLOAD: begin
            m_tready = 1'b1;
            if (m_hs && j_last) state_next = FLUSH;
         end
         FLUSH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- load path
   assign s_tvalid  = out_v;
   assign s_tdata   = {16'h0000, out_data};
   // snd_cnt only advances on a handshake, so tlast holds steady under stall.
   assign s_tlast   = out_v && (&snd_cnt);
   assign s_pop     = out_v && s_tready;

   // Items held once this cycle's pop and BRAM capture settle. A read issued now
   // lands a cycle later, so allow it only when at most one slot is occupied.
   // That keeps one beat per cycle and never overflows the two registers.
   assign occ_now   = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, rd_vld};
   assign occ_next  = occ_now - {1'b0, s_pop};
   assign rd_issue  = (state == LOAD) && !rd_cnt[LOG2N] && (occ_next <= 2'd1);
   assign sbuf_en   = rd_issue;
   assign sbuf_addr = rd_cnt[LOG2N-1:0];

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cfg_sent  <= 1'b0;
         rd_cnt    <= '0;
         snd_cnt   <= '0;
         rd_vld    <= 1'b0;
         out_v     <= 1'b0;
         skid_v    <= 1'b0;
         out_data  <= '0;
         skid_data <= '0;
      end else begin
         if (cfg_hs) cfg_sent <= 1'b1;

         if (accept) begin
            rd_cnt  <= '0;
            snd_cnt <= '0;
         end else begin
            if (rd_issue) rd_cnt  <= rd_cnt + 1'b1;
            if (s_pop)    snd_cnt <= snd_cnt + 1'b1;
         end
         rd_vld <= rd_issue;

         // Oldest item sits in out_data, next in skid_data, newest on sbuf_dout.
         if (s_pop) begin
            if (skid_v) begin
               out_data <= skid_data;
               skid_v   <= rd_vld;
               if (rd_vld) skid_data <= sbuf_dout;
            end else begin
               out_v <= rd_vld;
               if (rd_vld) out_data <= sbuf_dout;
            end
         end else if (rd_vld) begin
            if (!out_v) begin
               out_v    <= 1'b1;
               out_data <= sbuf_dout;
            end else begin
               skid_v    <= 1'b1;
               skid_data <= sbuf_dout;
            end
         end
      end
   end

   // ---------------------------------------------------------------- unload path
   function automatic logic [15:0] abs16(input logic [15:0] v);
      // -32768 maps to 16'h8000, which is 32768 read as unsigned.
      return v[15] ? (~v + 16'd1) : v;
   endfunction

   assign m_hs   = m_tvalid && (state == UNLOAD);
   assign j_last = &j_cnt;
   assign abs_re = abs16(m_tdata[15:0]);
   assign abs_im = abs16(m_tdata[31:16]);
   assign mag_hi = (abs_re > abs_im) ? abs_re : abs_im;
   assign mag_lo = (abs_re > abs_im) ? abs_im : abs_re;
   assign mag    = mag_hi + (mag_lo >> 1);
   assign obuf_en = obuf_we;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         j_cnt     <= '0;
         obuf_we   <= 1'b0;
         obuf_addr <= '0;
         obuf_din  <= '0;
         err       <= 1'b0;
         done      <= 1'b0;
      end else begin
         done    <= (state == FLUSH);
         obuf_we <= m_hs && !j_cnt[LOG2N-1];
         if (m_hs && !j_cnt[LOG2N-1]) begin
            obuf_addr <= j_cnt;
            obuf_din  <= mag;
         end

         if (accept)    j_cnt <= '0;
         else if (m_hs) j_cnt <= j_cnt + 1'b1;

         if (accept)
            err <= 1'b0;
         else if (m_hs && (m_tlast != j_last))
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer
//   Plays the sample buffer BRAM and the xfft core around fft_frame_sequencer.
//   Expected config beats, input beats and output-buffer writes are pushed into
//   queues when stimulus is issued; a negedge monitor pops and compares them.
module tb_fft_frame_sequencer;

   localparam int          LOG2N = 10;
   localparam int          N     = 1 << LOG2N;
   localparam logic [15:0] CFG   = 16'h0001;

   logic             clock, reset_n, start;
   logic             busy, done, err;
   logic             sbuf_en;
   logic [LOG2N-1:0] sbuf_addr;
   logic [15:0]      sbuf_dout;
   logic [15:0]      cfg_tdata;
   logic             cfg_tvalid, cfg_tready;
   logic [31:0]      s_tdata;
   logic             s_tvalid, s_tready, s_tlast;
   logic [31:0]      m_tdata;
   logic             m_tvalid, m_tready, m_tlast;
   logic             obuf_en, obuf_we;
   logic [LOG2N-1:0] obuf_addr;
   logic [15:0]      obuf_din;

   fft_frame_sequencer #(.LOG2N(LOG2N), .CFG_WORD(CFG)) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .busy(busy), .done(done), .err(err),
      .sbuf_en(sbuf_en), .sbuf_addr(sbuf_addr), .sbuf_dout(sbuf_dout),
      .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .obuf_en(obuf_en), .obuf_we(obuf_we), .obuf_addr(obuf_addr), .obuf_din(obuf_din)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Sample buffer BRAM with one cycle of read latency.
   logic [15:0] sbuf_mem [N];
   always @(posedge clock) if (sbuf_en) sbuf_dout <= sbuf_mem[sbuf_addr];

   typedef struct packed { logic [31:0] data; logic last; } s_beat_t;
   typedef struct packed { logic [9:0] addr; logic [15:0] mag; } wr_t;

   s_beat_t     s_q[$];
   logic [15:0] cfg_q[$];
   wr_t         wr_q[$];

   int  checks = 0;
   int  errors = 0;
   bit  model_cfg_sent = 0;
   bit  bp = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got an unexpected beat, expected none", name);
   endtask

   // Reference magnitude: max(|re|,|im|) + min(|re|,|im|)/2 in plain integers.
   function automatic int ref_mag(input logic [31:0] d);
      int re, im, a, b;
      re = int'($signed(d[15:0]));
      im = int'($signed(d[31:16]));
      a  = (re < 0) ? -re : re;
      b  = (im < 0) ? -im : im;
      return ((a > b) ? a : b) + (((a > b) ? b : a) / 2);
   endfunction

   function automatic logic [93:0] all_outs();
      return {busy, done, err, sbuf_en, sbuf_addr, cfg_tdata, cfg_tvalid,
              s_tdata, s_tvalid, s_tlast, m_tready, obuf_en, obuf_we, obuf_addr, obuf_din};
   endfunction

   // Core-side ready generators.
   initial begin
      s_tready   = 1'b1;
      cfg_tready = 1'b1;
      forever begin
         @(posedge clock); #1;
         s_tready   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         cfg_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------------------------------------------------------- monitor
   int      s_cnt = 0;
   int      first_s_cyc = 0;
   int      last_s_cyc = 0;
   bit      stalled = 0;
   s_beat_t held;

   always @(negedge clock) begin
      s_beat_t sb;
      wr_t     wr;
      if (!reset_n) begin
         s_cnt   = 0;
         stalled = 0;
      end else begin
         if (start) s_cnt = 0;
         if (cfg_tvalid && cfg_tready) begin
            if (cfg_q.size() == 0) unexpected("cfg_extra_beat");
            else check("cfg_tdata", cfg_tdata, cfg_q.pop_front());
         end
         if (stalled) begin
            check("s_held_valid", s_tvalid, 1'b1);
            check("s_held_data", s_tdata, held.data);
            check("s_held_last", s_tlast, held.last);
         end
         stalled = 0;
         if (s_tvalid) begin
            if (s_tready) begin
               if (s_q.size() == 0) unexpected("s_extra_beat");
               else begin
                  sb = s_q.pop_front();
                  check("s_tdata", s_tdata, sb.data);
                  check("s_tlast", s_tlast, sb.last);
               end
               if (s_cnt == 0) first_s_cyc = cyc;
               last_s_cyc = cyc;
               s_cnt++;
            end else begin
               stalled   = 1;
               held.data = s_tdata;
               held.last = s_tlast;
            end
         end
         if (obuf_we) begin
            check("obuf_en", obuf_en, 1'b1);
            if (wr_q.size() == 0) unexpected("obuf_extra_write");
            else begin
               wr = wr_q.pop_front();
               check("obuf_addr", obuf_addr, wr.addr);
               check("obuf_din", obuf_din, wr.mag);
            end
         end
      end
   end

   // ---------------------------------------------------------------- frame helpers
   task automatic load_frame(input bit ramp, output bit exp_cfg);
      for (int k = 0; k < N; k++) begin
         sbuf_mem[k] = ramp ? 16'(k) : 16'($urandom);
         s_q.push_back('{data: {16'h0000, sbuf_mem[k]}, last: (k == N - 1)});
      end
      exp_cfg = !model_cfg_sent;
      if (exp_cfg) cfg_q.push_back(CFG);
      model_cfg_sent = 1;
   endtask

   task automatic pulse_start(input bit exp_cfg, output int t_cyc);
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      @(negedge clock);
      t_cyc = cyc;
      check("start_busy", busy, 1'b1);
      check("start_cfg_tvalid", cfg_tvalid, exp_cfg);
      check("start_sbuf_en", sbuf_en, !exp_cfg);
      check("start_sbuf_addr", sbuf_addr, 0);
      check("start_err_clear", err, 1'b0);
   endtask

   function automatic logic [31:0] gen_beat(input int j, input bit special);
      if (special && j == 5) return {16'h0000, 16'h8000};   // re=-32768, im=0
      if (special && j == 6) return {16'hFFFC, 16'h0003};   // re=3, im=-4
      return $urandom;
   endfunction

   task automatic run_frame(input bit ramp, input bit bp_mode, input int tlast_pos,
                            input bit special, input bit coincide);
      bit exp_cfg;
      int t_cyc, n, j, last_m_cyc;
      bit took;
      bp = bp_mode;
      load_frame(ramp, exp_cfg);
      pulse_start(exp_cfg, t_cyc);

      n = 0;
      while (s_cnt < N && n < 10000) begin
         @(negedge clock);
         n++;
      end
      check("load_beat_count", s_cnt, N);
      if (!bp_mode) begin
         check("load_first_latency", first_s_cyc - t_cyc, exp_cfg ? 3 : 2);
         check("load_rate", last_s_cyc - first_s_cyc, N - 1);
      end

      // Output side of the core: random valid gaps, data held until taken.
      j = 0; n = 0; took = 0; last_m_cyc = 0;
      while (j < N && n < 20000) begin
         @(posedge clock); #1;
         if (took || !m_tvalid) begin
            if ($urandom_range(0, 3) != 0) begin
               m_tvalid = 1'b1;
               m_tdata  = gen_beat(j, special);
               m_tlast  = (j == tlast_pos);
            end else begin
               m_tvalid = 1'b0;
               m_tlast  = 1'b0;
            end
         end
         @(negedge clock);
         took = m_tvalid && m_tready;
         if (took) begin
            if (j < N / 2) wr_q.push_back('{addr: 10'(j), mag: 16'(ref_mag(m_tdata))});
            last_m_cyc = cyc;
            j++;
         end
         n++;
      end
      check("unload_beat_count", j, N);

      @(posedge clock); #1;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      @(posedge clock); #1;
      if (coincide) start = 1'b1;
      @(negedge clock);
      check("done_pulse", done, 1'b1);
      check("done_latency", cyc - last_m_cyc, 2);
      check("done_busy_low", busy, 1'b0);
      check("done_err", err, tlast_pos != N - 1);
      @(posedge clock); #1 start = 1'b0;
      @(negedge clock);
      check("done_single_cycle", done, 1'b0);
      check("post_done_idle", {busy, cfg_tvalid, sbuf_en}, 3'b000);
      check("cfg_q_drained", cfg_q.size(), 0);
      check("s_q_drained", s_q.size(), 0);
      check("wr_q_drained", wr_q.size(), 0);
   endtask

   task automatic reset_mid_load();
      bit exp_cfg;
      int t_cyc, n;
      bp = 1'b0;
      load_frame(1'b0, exp_cfg);
      pulse_start(exp_cfg, t_cyc);
      n = 0;
      while (s_cnt < 300 && n < 2000) begin
         @(negedge clock);
         n++;
      end
      check("mid_load_reached", s_cnt, 300);
      #2 reset_n = 1'b0;
      #1 check("reset_mid_outputs", all_outs(), '0);
      s_q.delete();
      cfg_q.delete();
      wr_q.delete();
      model_cfg_sent = 0;
      repeat (3) @(posedge clock);
      #1 check("reset_held_outputs", all_outs(), '0);
      @(negedge clock) reset_n = 1'b1;
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      m_tvalid = 1'b0;
      m_tdata  = '0;
      m_tlast  = 1'b0;
      repeat (3) @(posedge clock);
      #1 check("reset_outputs", all_outs(), '0);
      @(negedge clock) reset_n = 1'b1;

      run_frame(1'b1, 1'b0, N - 1, 1'b1, 1'b0);   // ramp, config, obuf[5]/[6]
      run_frame(1'b0, 1'b0, 1000,  1'b0, 1'b1);   // early tlast, start on done
      run_frame(1'b0, 1'b1, N - 1, 1'b1, 1'b0);   // backpressure, err cleared
      reset_mid_load();
      run_frame(1'b0, 1'b1, N - 1, 1'b0, 1'b0);   // config again after reset

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
